// File: rtl/tt_i2c_eeprom_target.sv
// tt_i2c_eeprom_target
// I2C target that behaves like a small 24Cxx-style EEPROM: the word pointer is
// set by a write, data bytes are written sequentially, and sequential reads
// stream bytes from the pointer. Contents can also be preloaded from a side
// port while the bus is not addressing this target.
//
// Ports:
//   clk, rst            system clock (>= 8x SCL), synchronous active-high reset
//   scl_i, sda_i        asynchronous pad inputs
//   sda_o, sda_oe_n     open-drain SDA drive (sda_o fixed 0, oe_n=0 pulls low)
//   cfg_we/addr/data    preload write port, ignored while busy
//   busy                high from an address match until STOP, NACK or mismatch
module tt_i2c_eeprom_target #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  sda_oe_n,
  input  logic                  cfg_we,
  input  logic [DEPTH_LOG2-1:0] cfg_addr,
  input  logic [7:0]            cfg_data,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_WADDR, S_WADDR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_ACK, S_IGNORE
  } state_t;

  // Synchronizers and previous-value registers (not reset: they must keep
  // tracking the bus so a reset never fabricates a START or STOP).
  logic scl_s1_q, scl_s2_q, scl_prev_q;
  logic sda_s1_q, sda_s2_q, sda_prev_q;

  always_ff @(posedge clk) begin
    scl_s1_q   <= scl_i;
    scl_s2_q   <= scl_s1_q;
    scl_prev_q <= scl_s2_q;
    sda_s1_q   <= sda_i;
    sda_s2_q   <= sda_s1_q;
    sda_prev_q <= sda_s2_q;
  end

  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_s2_q & ~scl_prev_q;
  assign scl_fall = ~scl_s2_q & scl_prev_q;
  assign start_ev = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
  logic                    busy_q, busy_d;
  logic                    sda_oe_n_q, sda_oe_n_d;
  logic                    rw_q, rw_d;
  logic [7:0]              sr_q, sr_d;
  logic [7:0]              mem_q [DEPTH];

  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [7:0]              mem_wdata;
  logic [7:0]              byte_in;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    sda_oe_n_d = sda_oe_n_q;
    rw_d       = rw_q;
    sr_d       = sr_q;
    mem_we     = 1'b0;
    mem_waddr  = ptr_q;
    mem_wdata  = sr_q;
    byte_in    = {sr_q[6:0], sda_s2_q};

    if (stop_ev) begin
      state_d    = S_IDLE;
      cnt_d      = 4'd0;
      busy_d     = 1'b0;
      sda_oe_n_d = 1'b1;
    end else if (start_ev) begin
      state_d    = S_DEV;
      cnt_d      = 4'd0;
      sda_oe_n_d = 1'b1;
    end else begin
      unique case (state_q)
        S_DEV: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rw_d = sda_s2_q;
              if (sr_q[6:0] == DEV_ADDR) begin
                state_d = S_DEV_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        S_WADDR, S_WDATA: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (state_q == S_WADDR) begin
                ptr_d   = byte_in[DEPTH_LOG2-1:0];
                state_d = S_WADDR_ACK;
              end else begin
                state_d = S_WDATA_ACK;
              end
            end
          end
        end
        // ACK states enter with cnt=8; the first SCL fall drives the ACK
        // (cnt=9), the second fall ends the ACK clock and hands the bus on.
        S_DEV_ACK, S_WADDR_ACK, S_WDATA_ACK: begin
          if (scl_rise && state_q == S_WDATA_ACK && cnt_q == 4'd9) begin
            mem_we = 1'b1;
            ptr_d  = ptr_q + DEPTH_LOG2'(1);
          end
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_n_d = 1'b0;
              cnt_d      = 4'd9;
            end else begin
              sda_oe_n_d = 1'b1;
              cnt_d      = 4'd0;
              if (state_q == S_DEV_ACK && rw_q) begin
                sr_d       = mem_q[ptr_q];
                sda_oe_n_d = mem_q[ptr_q][7];
                state_d    = S_RDATA;
              end else if (state_q == S_DEV_ACK) begin
                state_d = S_WADDR;
              end else begin
                state_d = S_WDATA;
              end
            end
          end
        end
        // The MSB is already on the bus on entry; each later fall shifts
        // the next bit out until all eight have been clocked.
        S_RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_n_d = 1'b1;
              state_d    = S_RD_ACK;
            end else begin
              sr_d       = {sr_q[6:0], 1'b0};
              sda_oe_n_d = sr_q[6];
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s2_q) begin
              state_d = S_IGNORE;
              busy_d  = 1'b0;
            end else begin
              ptr_d = ptr_q + DEPTH_LOG2'(1);
              cnt_d = 4'd9;
            end
          end
          if (scl_fall && cnt_q == 4'd9) begin
            sr_d       = mem_q[ptr_q];
            sda_oe_n_d = mem_q[ptr_q][7];
            cnt_d      = 4'd0;
            state_d    = S_RDATA;
          end
        end
        default: ;
      endcase
    end

    if (!mem_we && cfg_we && !busy_q) begin
      mem_we    = 1'b1;
      mem_waddr = cfg_addr;
      mem_wdata = cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      sda_oe_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      sda_oe_n_q <= sda_oe_n_d;
    end
  end

  always_ff @(posedge clk) begin
    rw_q <= rw_d;
    sr_q <= sr_d;
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign sda_o    = 1'b0;
  assign sda_oe_n = sda_oe_n_q;
  assign busy     = busy_q;

endmodule

// File: doc/tt_i2c_eeprom_target.md
# tt_i2c_eeprom_target

I2C target (responder) modelling a small 24Cxx-style EEPROM. It answers the I2C controller in the chip's auto-select logic, which addresses a target, sets a word pointer, then issues a repeated-START sequential read. Used as a synthesizable on-chip stand-in and as the bench partner for that controller. Contents are preloaded through a side configuration port and can also be written over I2C.

## Interface
Parameters:
- DEV_ADDR, 7'h50, 7-bit target address that the block acknowledges.
- DEPTH_LOG2, 4, log2 of the memory depth in bytes (default 16 bytes).

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- rst  input  1  reset, synchronous, active-high.
- scl_i  input  1  SCL pad input; asynchronous to clk.
- sda_i  input  1  SDA pad input; asynchronous to clk.
- sda_o  output  1  SDA output value; tied 0 (open-drain).
- sda_oe_n  output  1  SDA output enable, active-low; 0 pulls SDA low, 1 releases it.
- cfg_we  input  1  preload write strobe.
- cfg_addr  input  DEPTH_LOG2  preload byte address.
- cfg_data  input  8  preload byte.
- busy  output  1  high from an address-matched START until STOP, NACK or mismatch.

## Operation
- **Input conditioning.** scl_i and sda_i each pass through a 2-flop synchronizer, followed by a previous-value register.
- **Event detection** (on synchronized signals):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bits are sampled on SCL rising edges.
  - sda_oe_n changes only on SCL falling edges.
- **FSM states:** IDLE, DEV, DEV_ACK, WADDR, WADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, IGNORE.
- **IDLE.** START moves to DEV; the bit counter clears.
- **DEV.** Shift in 8 bits, MSB first.
  - If bits[7:1] equal DEV_ADDR, go to DEV_ACK and set busy.
  - Otherwise go to IGNORE.
- **DEV_ACK.** Drive SDA low for one SCL-low/high period. Then:
  - R/W=0 goes to WADDR.
  - R/W=1 loads the shift register from mem[ptr] and goes to RDATA.
- **WADDR.** Shift in 8 bits. ptr takes the low DEPTH_LOG2 bits; the upper bits are ignored. ACK in WADDR_ACK, then go to WDATA.
- **WDATA.** Shift in 8 bits, then in WDATA_ACK:
  - write mem[ptr];
  - ptr increments;
  - ACK;
  - return to WDATA.
- **RDATA.** Present the shift-register MSB on each SCL falling edge:
  - bit=0 gives sda_oe_n=0;
  - bit=1 gives sda_oe_n=1.
  - After 8 bits, release SDA and go to RD_ACK.
- **RD_ACK.** Sample SDA on the SCL rise.
  - ACK (0): ptr increments, reload from mem[ptr], back to RDATA.
  - NACK (1): go to IGNORE and clear busy.
- **IGNORE.** SDA stays released; wait for START or STOP.
- **START in any state** (repeated START) goes to DEV. ptr and memory are preserved.
- **STOP in any state** goes to IDLE, releases SDA and clears busy.
- **Pointer arithmetic.** ptr is DEPTH_LOG2 bits and wraps modulo 2^DEPTH_LOG2; the last address increments to 0.
- **Preload port.** cfg_we writes mem[cfg_addr]=cfg_data only when busy=0; it is ignored while busy=1.
- **Reset values:**
  - sda_oe_n=1, sda_o=0, busy=0;
  - ptr=0, FSM=IDLE, bit counter=0;
  - memory contents are not cleared.
- **Reset mid-transfer.** SDA is released the cycle after rst. The block stays in IDLE until the next START; it does not resynchronize mid-byte.

## Timing
- **Input latency.** Pad to internal event: 2 clk (synchronizer) plus 1 clk (edge detect).
- **SDA drive.** sda_oe_n updates in the clk cycle after the SCL-fall event is detected, i.e. 3 clk after scl_i falls. It is registered with no combinational path from the inputs.
- **Bus requirements.** SCL high and low each last ≥4 clk. Controller data setup before the SCL rise is ≥3 clk.
- **Memory write.** Takes effect in the cycle of the 9th SCL rise of a WDATA byte (ACK clock) detection. A read of that address in the next transaction returns the new value.
- **cfg_we.** Writes on the same clk edge it is sampled; there is no pipeline.
- **busy timing.**
  - Rises on the cycle the 8th DEV bit matches.
  - Falls on the cycle STOP is detected or NACK is sampled.

## Test plan
- **Preload and random read.** Preload mem[i]=8'hA0+i. Run START, 0xA0, ACK, 0x03, ACK, Sr, 0xA1, ACK, read 3 bytes with ACK, ACK, NACK, STOP. Required: target ACKs all address bytes; data = A3, A4, A5; busy returns to 0 at NACK; SDA released.
- **Wrap.** Set ptr=0x0F and read 2 bytes. Required: data = AF, A0.
- **Address mismatch.** Send 0xA2 (address 0x51). Required: 9th bit NACK (SDA released); busy stays 0; no SDA activity until STOP.
- **I2C write.** Write 0x5A, 0x5B at word 0x0E, then read back from 0x0E. Required: 5A, 5B. Upper word-address bits: 0x1E behaves the same as 0x0E.
- **Preload while busy.** cfg_we to mem[2] while busy=1 has no effect; the same write with busy=0 takes effect.
- **Reset mid-read.** Assert rst during bit 4 of RDATA while driving a 0. Required: sda_oe_n=1 the next cycle; further SCL edges are ignored until a new START; the following transaction works normally.
